// File: rtl/mole_scheduler_if.sv
// Game-control bus between the whack-a-mole scheduler and its environment.
// master: drives random/start/btn and observes the game outputs.
// slave : the scheduler; consumes random/start/btn and drives the game outputs.
//   random    [7:0] PRNG word, sampled at GAP expiry
//   start           single-cycle game start pulse
//   btn       [7:0] one-hot hit pulses, bit n = mole n
//   mole_idx  [2:0] current or last mole index (7-seg decoder input)
//   mole_vis        high while a mole is up
//   score     [7:0] saturating hit count
//   misses    [3:0] miss count
//   game_over       high in the OVER state
interface mole_scheduler_if;
    logic [7:0] random;
    logic       start;
    logic [7:0] btn;
    logic [2:0] mole_idx;
    logic       mole_vis;
    logic [7:0] score;
    logic [3:0] misses;
    logic       game_over;

    modport master (
        output random,
        output start,
        output btn,
        input  mole_idx,
        input  mole_vis,
        input  score,
        input  misses,
        input  game_over
    );

    modport slave (
        input  random,
        input  start,
        input  btn,
        output mole_idx,
        output mole_vis,
        output score,
        output misses,
        output game_over
    );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: picks a mole from the PRNG word at the end of
// each gap, times the up/gap phases with a tick prescaler, scores one-hot hits
// and ends the game after MISS_LIMIT unhit moles.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  mole_scheduler_if.slave (random/start/btn in; mole_idx, mole_vis,
//        score, misses, game_over out; all outputs registered)
// Optional feature: define MOLE_NO_REPEAT_EN to forbid the same mole popping
// twice in a row (a repeated pick is bumped to the next index, mod 8).
module mole_scheduler #(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned UP_TICKS   = 8,
    parameter int unsigned GAP_TICKS  = 4,
    parameter int unsigned MISS_LIMIT = 5
) (
    input  logic             clk,
    input  logic             rst,
    mole_scheduler_if.slave  bus
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [7:0]       UP_LOAD   = 8'(UP_TICKS);
    localparam logic [7:0]       GAP_LOAD  = 8'(GAP_TICKS);
    localparam logic [3:0]       MISS_LAST = 4'(MISS_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] prescale;
    logic [7:0]       ticks_left;
    logic [2:0]       mole_idx;
    logic             mole_vis;
    logic [7:0]       score;
    logic [3:0]       misses;
    logic             game_over;

    logic             tick;
    logic             expire;
    logic             hit;
    logic [2:0]       next_idx;
    logic [7:0]       score_inc;
    logic [3:0]       miss_inc;
    logic             unused_random;

    // Only the low three PRNG bits select a mole.
    assign unused_random = ^bus.random[7:3];

    // Phase timing: one tick per prescaler wrap, expiry on the tick that
    // takes the remaining count to zero.
    assign tick   = (prescale == PRE_LAST);
    assign expire = tick && (ticks_left == 8'd1);

    // Only the button under the visible mole counts; others are ignored.
    assign hit = bus.btn[mole_idx];

    assign score_inc = (score == 8'hFF) ? score : 8'(score + 8'd1);
    assign miss_inc  = 4'(misses + 4'd1);

`ifdef MOLE_NO_REPEAT_EN
    // A repeated pick is bumped to the next mole so the player never sees
    // the same hole twice in a row; mole_idx still holds the previous pick.
    assign next_idx = (bus.random[2:0] == mole_idx) ? 3'(mole_idx + 3'd1)
                                                    : bus.random[2:0];
`else
    assign next_idx = bus.random[2:0];
`endif

    // Game state machine; prescaler and tick counter restart on every
    // transition so each phase has an exact length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prescale   <= '0;
            ticks_left <= 8'd0;
            mole_idx   <= 3'd0;
            mole_vis   <= 1'b0;
            score      <= 8'd0;
            misses     <= 4'd0;
            game_over  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    prescale <= '0;
                    if (bus.start) begin
                        score      <= 8'd0;
                        misses     <= 4'd0;
                        ticks_left <= GAP_LOAD;
                        state      <= GAP;
                    end
                end

                GAP: begin
                    if (expire) begin
                        mole_idx   <= next_idx;
                        mole_vis   <= 1'b1;
                        ticks_left <= UP_LOAD;
                        prescale   <= '0;
                        state      <= UP;
                    end else begin
                        prescale <= tick ? '0 : PRE_W'(prescale + 1'b1);
                        if (tick) begin
                            ticks_left <= 8'(ticks_left - 8'd1);
                        end
                    end
                end

                UP: begin
                    // A hit on the expiry cycle takes priority over the miss.
                    if (hit) begin
                        score      <= score_inc;
                        mole_vis   <= 1'b0;
                        ticks_left <= GAP_LOAD;
                        prescale   <= '0;
                        state      <= GAP;
                    end else if (expire) begin
                        misses   <= miss_inc;
                        mole_vis <= 1'b0;
                        prescale <= '0;
                        if (miss_inc == MISS_LAST) begin
                            ticks_left <= 8'd0;
                            game_over  <= 1'b1;
                            state      <= OVER;
                        end else begin
                            ticks_left <= GAP_LOAD;
                            state      <= GAP;
                        end
                    end else begin
                        prescale <= tick ? '0 : PRE_W'(prescale + 1'b1);
                        if (tick) begin
                            ticks_left <= 8'(ticks_left - 8'd1);
                        end
                    end
                end

                OVER: begin
                    prescale <= '0;
                    if (bus.start) begin
                        score      <= 8'd0;
                        misses     <= 4'd0;
                        game_over  <= 1'b0;
                        ticks_left <= GAP_LOAD;
                        state      <= GAP;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mole_idx  = mole_idx;
    assign bus.mole_vis  = mole_vis;
    assign bus.score     = score;
    assign bus.misses    = misses;
    assign bus.game_over = game_over;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed testbench for mole_scheduler with TICK_DIV=4, GAP_TICKS=2,
// UP_TICKS=3, MISS_LIMIT=2: gap = 8 cycles, up = 12 cycles.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mole_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [2:0] prev_idx;

    mole_scheduler_if bus();

    mole_scheduler #(
        .TICK_DIV   (4),
        .UP_TICKS   (3),
        .GAP_TICKS  (2),
        .MISS_LIMIT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count falling edges until mole_vis equals val, bounded by max.
    task automatic wait_vis(input logic val, input int max, output int n);
        n = 0;
        while (bus.mole_vis !== val && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Expected mole for a given PRNG word, tracking the previous pick.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] prev);
        logic [2:0] p;
        p = r[2:0];
`ifdef MOLE_NO_REPEAT_EN
        if (p == prev) p = 3'(p + 3'd1);
`endif
        return p;
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.random = 8'h00;
        bus.start  = 1'b0;
        bus.btn    = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mole_idx, bus.mole_vis, bus.score, bus.misses, bus.game_over} !== 17'd0) begin
            errors++;
            $display("FAIL reset_values: got idx=%0d vis=%0d score=%0d misses=%0d over=%0d, expected all 0",
                     bus.mole_idx, bus.mole_vis, bus.score, bus.misses, bus.game_over);
        end
        rst = 1'b0;
        // Buttons in IDLE do nothing and no mole appears without start.
        bus.btn = 8'hFF;
        @(negedge clk);
        bus.btn = 8'h00;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.score !== 8'd0 || bus.mole_vis !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_btn: got score=%0d vis=%0d, expected 0 0", bus.score, bus.mole_vis);
        end
        prev_idx = 3'd0;
    endtask

    task automatic test_phase_lengths();
        int n;
        bus.random = 8'h05;
        pulse_start();
        wait_vis(1'b1, 40, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL gap_length: got %0d cycles, expected 8", n);
        end
        checks++;
        if (bus.mole_idx !== pick(8'h05, prev_idx)) begin
            errors++;
            $display("FAIL first_idx: got %0d, expected %0d", bus.mole_idx, pick(8'h05, prev_idx));
        end
        prev_idx = pick(8'h05, prev_idx);
        wait_vis(1'b0, 40, n);
        checks++;
        if (n !== 12) begin
            errors++;
            $display("FAIL up_length: got %0d cycles, expected 12", n);
        end
        checks++;
        if (bus.misses !== 4'd1 || bus.game_over !== 1'b0 || bus.score !== 8'd0) begin
            errors++;
            $display("FAIL first_miss: got misses=%0d over=%0d score=%0d, expected 1 0 0",
                     bus.misses, bus.game_over, bus.score);
        end
    endtask

    task automatic test_game_over();
        int n;
        bus.random = 8'h02;
        wait_vis(1'b1, 40, n);
        checks++;
        if (n !== 8 || bus.mole_idx !== 3'd2) begin
            errors++;
            $display("FAIL second_pop: got %0d cycles idx=%0d, expected 8 cycles idx=2", n, bus.mole_idx);
        end
        prev_idx = 3'd2;
        // A start pulse during UP must not disturb the phase.
        pulse_start();
        wait_vis(1'b0, 40, n);
        checks++;
        if (n !== 11) begin
            errors++;
            $display("FAIL start_in_up: got %0d remaining cycles, expected 11", n);
        end
        checks++;
        if (bus.misses !== 4'd2 || bus.game_over !== 1'b1) begin
            errors++;
            $display("FAIL game_over: got misses=%0d over=%0d, expected 2 1", bus.misses, bus.game_over);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (bus.game_over !== 1'b1 || bus.mole_vis !== 1'b0 || bus.mole_idx !== 3'd2 || bus.misses !== 4'd2) begin
            errors++;
            $display("FAIL over_hold: got over=%0d vis=%0d idx=%0d misses=%0d, expected 1 0 2 2",
                     bus.game_over, bus.mole_vis, bus.mole_idx, bus.misses);
        end
        pulse_start();
        checks++;
        if (bus.game_over !== 1'b0 || bus.misses !== 4'd0 || bus.score !== 8'd0) begin
            errors++;
            $display("FAIL restart: got over=%0d misses=%0d score=%0d, expected 0 0 0",
                     bus.game_over, bus.misses, bus.score);
        end
    endtask

    task automatic test_hit();
        int n;
        bus.random = 8'h05;
        wait_vis(1'b1, 40, n);
        checks++;
        if (n !== 8 || bus.mole_idx !== 3'd5) begin
            errors++;
            $display("FAIL restart_gap: got %0d cycles idx=%0d, expected 8 cycles idx=5", n, bus.mole_idx);
        end
        prev_idx = 3'd5;
        bus.btn = 8'h01;
        @(negedge clk);
        bus.btn = 8'h00;
        checks++;
        if (bus.mole_vis !== 1'b1 || bus.score !== 8'd0 || bus.misses !== 4'd0) begin
            errors++;
            $display("FAIL wrong_btn: got vis=%0d score=%0d misses=%0d, expected 1 0 0",
                     bus.mole_vis, bus.score, bus.misses);
        end
        bus.btn = 8'h20;
        @(negedge clk);
        bus.btn = 8'h00;
        checks++;
        if (bus.mole_vis !== 1'b0 || bus.score !== 8'd1) begin
            errors++;
            $display("FAIL hit: got vis=%0d score=%0d, expected 0 1", bus.mole_vis, bus.score);
        end
    endtask

    task automatic test_no_repeat();
        int n;
        logic [2:0] exp_idx;
        // Start during GAP is ignored; the gap keeps its length.
        pulse_start();
        wait_vis(1'b1, 40, n);
        checks++;
        if (n !== 7) begin
            errors++;
            $display("FAIL start_in_gap: got %0d remaining cycles, expected 7", n);
        end
`ifdef MOLE_NO_REPEAT_EN
        exp_idx = 3'd6;
`else
        exp_idx = 3'd5;
`endif
        checks++;
        if (bus.mole_idx !== exp_idx) begin
            errors++;
            $display("FAIL no_repeat: got idx=%0d, expected %0d", bus.mole_idx, exp_idx);
        end
        prev_idx = exp_idx;
    endtask

    task automatic test_collision();
        // Mole is up at this sample; the expiry cycle is 11 cycles later.
        repeat (11) @(negedge clk);
        checks++;
        if (bus.mole_vis !== 1'b1) begin
            errors++;
            $display("FAIL pre_expiry_vis: got %0d, expected 1", bus.mole_vis);
        end
        bus.btn = 8'(1) << prev_idx;
        @(negedge clk);
        bus.btn = 8'h00;
        checks++;
        if (bus.score !== 8'd2 || bus.misses !== 4'd0 || bus.mole_vis !== 1'b0) begin
            errors++;
            $display("FAIL collision: got score=%0d misses=%0d vis=%0d, expected 2 0 0",
                     bus.score, bus.misses, bus.mole_vis);
        end
    endtask

    task automatic test_saturation();
        int n;
        logic [7:0] r;
        logic [2:0] exp_idx;
        for (int k = 0; k < 254; k++) begin
            r = 8'(k * 37 + 3);
            bus.random = r;
            exp_idx = pick(r, prev_idx);
            wait_vis(1'b1, 40, n);
            checks++;
            if (n !== 8 || bus.mole_idx !== exp_idx) begin
                errors++;
                $display("FAIL sat_pop_%0d: got %0d cycles idx=%0d, expected 8 cycles idx=%0d",
                         k, n, bus.mole_idx, exp_idx);
            end
            prev_idx = exp_idx;
            bus.btn = 8'(1) << exp_idx;
            @(negedge clk);
            bus.btn = 8'h00;
            if (k == 252) begin
                checks++;
                if (bus.score !== 8'd255) begin
                    errors++;
                    $display("FAIL reach_255: got score=%0d, expected 255", bus.score);
                end
            end
        end
        checks++;
        if (bus.score !== 8'd255 || bus.misses !== 4'd0) begin
            errors++;
            $display("FAIL saturate: got score=%0d misses=%0d, expected 255 0", bus.score, bus.misses);
        end
    endtask

    task automatic test_reset_mid_up();
        int n;
        bus.random = 8'h01;
        wait_vis(1'b1, 40, n);
        checks++;
        if (bus.mole_vis !== 1'b1) begin
            errors++;
            $display("FAIL mid_up_setup: got vis=%0d, expected 1", bus.mole_vis);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.mole_idx, bus.mole_vis, bus.score, bus.misses, bus.game_over} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset: got idx=%0d vis=%0d score=%0d misses=%0d over=%0d, expected all 0",
                     bus.mole_idx, bus.mole_vis, bus.score, bus.misses, bus.game_over);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mole_vis !== 1'b0 || bus.game_over !== 1'b0) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL idle_after_reset: %0d cycles with activity, expected 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_phase_lengths();
        test_game_over();
        test_hit();
        test_no_repeat();
        test_collision();
        test_saturation();
        test_reset_mid_up();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Game-control stage directly downstream of the LFSR PRNG in the whack-a-mole datapath. It samples the 8-bit random word to choose which of 8 moles pops up, times the up/gap phases, checks one-hot player hits, and keeps score and miss counts. Its `mole_idx` output replaces the raw random bits that drive the seven-segment decoder.

## Interface
Parameters:
- `TICK_DIV`, 1000: clock cycles per game tick; ≥ 2.
- `UP_TICKS`, 8: ticks a mole stays visible; 1–255.
- `GAP_TICKS`, 4: ticks with no mole between pops; 1–255.
- `MISS_LIMIT`, 5: misses that end the game; 1–15.

Ports:
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `random` in 8: PRNG word, assumed to change every cycle.
- `start` in 1: single-cycle pulse that begins a game.
- `btn` in 8: one-hot, debounced, single-cycle hit pulses; bit *n* is mole *n*.
- `mole_idx` out 3: index of the current or last mole; feeds the 7-seg decoder.
- `mole_vis` out 1: 1 while a mole is up.
- `score` out 8: hit count, saturating at 255.
- `misses` out 4: miss count.
- `game_over` out 1: 1 in the OVER state.

## Operation
- States are IDLE, GAP, UP and OVER. Reset enters IDLE.
- **Reset values:** `mole_idx`=0, `mole_vis`=0, `score`=0, `misses`=0, `game_over`=0; prescaler and tick counter are 0.
- **Prescaler:** counts 0..`TICK_DIV`-1 and pulses `tick` when it wraps. It clears to 0 on every state transition, so phase lengths are exact.
- **Tick counter:** loaded on state entry and decremented on each `tick`. The phase expires on the tick that takes it to 0.
- **IDLE:**
  - `start` clears `score` and `misses`, then goes to GAP.
  - `btn` is ignored.
- **GAP:**
  - Duration is `GAP_TICKS`.
  - On expiry, latch `random[2:0]` into `mole_idx`, set `mole_vis`=1, and go to UP.
  - `btn` is ignored.
- **UP:**
  - Duration is `UP_TICKS`.
  - If `btn[mole_idx]`=1: increment `score` (saturating), set `mole_vis`=0, go to GAP.
  - Bits of `btn` other than `mole_idx` are ignored, with no penalty.
  - On expiry with no hit:
    - Increment `misses` and set `mole_vis`=0.
    - If the new `misses` equals `MISS_LIMIT`, go to OVER; otherwise go to GAP.
- **OVER:**
  - `game_over`=1; `score`, `misses` and `mole_idx` hold.
  - `start` clears the counters, drops `game_over`, and goes to GAP.
- **Boundary cases:**
  - Hit and expiry in the same cycle: the hit wins, with no miss.
  - `start` in GAP or UP is ignored.
  - `score` at 255 stays at 255 on a hit.
  - `rst` mid-game returns immediately to the reset values and IDLE.

## Timing
- All outputs are registered. A decision made in cycle *t* is visible at cycle *t*+1.
- IDLE `start` in cycle *t*: GAP is entered at *t*+1.
- GAP length: `mole_vis` rises exactly `GAP_TICKS`×`TICK_DIV` cycles after GAP entry.
- UP length with no hit: `mole_vis` is high for exactly `UP_TICKS`×`TICK_DIV` cycles.
- Hit latency:
  - A hit pulse in cycle *t* gives `mole_vis`=0 and the `score` update at *t*+1.
  - The next GAP starts at *t*+1.
- The `random` sample point is the GAP expiry cycle. `mole_idx` is stable for the whole UP phase and the following GAP.

## Configuration
- `MOLE_NO_REPEAT_EN`, defined:
  - If `random[2:0]` equals the current `mole_idx`, latch (`random[2:0]`+1) mod 8 instead.
  - Same cycle, no added latency.
  - This rule applies to the first pop after `start` as well.
- Undefined: `random[2:0]` is latched unmodified, and repeats are allowed.

## Test plan
Common parameters: `TICK_DIV`=4, `GAP_TICKS`=2, `UP_TICKS`=3, `MISS_LIMIT`=2.

- **Reset values:** assert `rst` mid-UP → all outputs 0 asynchronously; state is IDLE, `mole_vis` stays 0 for 20 cycles without `start`.
- **Phase lengths:** `start`, force `random`=8'h05, no `btn` → `mole_vis` rises 8 cycles after GAP entry with `mole_idx`=5, stays high 12 cycles, then `misses`=1.
- **Hit:**
  - While `mole_idx`=5, pulse `btn`=8'h20 → next cycle `score`=1, `mole_vis`=0.
  - Pulse `btn`=8'h01 in UP → no change.
- **Game over:** two consecutive unhit moles → `misses`=2, `game_over`=1. Then `start` → `score`=0, `misses`=0, `game_over`=0, GAP.
- **Collision and saturation:**
  - Hit pulse on the UP expiry cycle → `score`+1, `misses` unchanged.
  - Preload `score`=255 and hit → stays 255.
- **No-repeat:** with `MOLE_NO_REPEAT_EN` defined, force `random`=8'h05 for two pops after a hit → second `mole_idx`=6. Undefined → 5.
